multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle processor.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the 2-bit aluop into the ALU decoder and all datapath mux/enable selects.
- Handles conditional R-type execution (ADC on carry, NDZ on zero), waits on a memory ready handshake, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [1:0]       cz,
  input  logic             carry,
  input  logic             zero,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             flagwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_RTEXEC, S_RTWB, S_ADIEXEC, S_ADIWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BEQ, S_JAL
  } state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic w_retire, w_cond, w_take;
  assign w_cond = (cz == 2'b10) || (cz == 2'b01);
  assign w_take = (cz == 2'b10) ? carry : zero;
  assign retired = r_retired;
  always_comb begin
    {iord, irwrite, pcwrite, memwrite, regwrite, flagwrite, alusrca} = '0;
    {alusrcb, aluop, pcsrc, regdst, memtoreg} = '0;
    illegal = 1'b0;
    w_retire = 1'b0;
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        w_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          4'b0000: begin
            illegal = !w_cond;
            w_retire = w_cond && !w_take;
            w_next = (w_cond && w_take) ? S_RTEXEC : S_FETCH;
          end
          4'b0001: w_next = S_ADIEXEC;
          4'b0100, 4'b0101: w_next = S_MEMADR;
          4'b1100: w_next = S_BEQ;
          4'b1000: w_next = S_JAL;
          default: illegal = 1'b1;
        endcase
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        aluop = 2'b10;
        w_next = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        flagwrite = 1'b1;
        w_retire = 1'b1;
      end
      S_ADIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next = S_ADIWB;
      end
      S_ADIWB: begin
        regdst = 2'b01;
        regwrite = 1'b1;
        flagwrite = 1'b1;
        w_retire = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next = (op == 4'b0101) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        iord = 1'b1;
        regdst = 2'b10;
        memtoreg = 2'b01;
        regwrite = 1'b1;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
        w_retire = mem_ready;
        w_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        aluop = 2'b01;
        pcwrite = alu_zero;
        w_retire = 1'b1;
      end
      S_JAL: begin
        regdst = 2'b10;
        memtoreg = 2'b10;
        regwrite = 1'b1;
        pcsrc = 2'b01;
        pcwrite = 1'b1;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset overrides the decode so an aborted instruction writes nothing
    if (!reset) begin
      {iord, irwrite, pcwrite, memwrite, regwrite, flagwrite, alusrca, illegal} = '0;
      {alusrcb, aluop, pcsrc, regdst, memtoreg} = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-step bench for multicycle_ctrl with immediate assertions
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;
  // bit order: iord irwrite pcwrite memwrite regwrite flagwrite alusrca alusrcb aluop pcsrc regdst memtoreg illegal
  localparam logic [17:0] V_ZERO   = 18'b0_0_0_0_0_0_0_00_00_00_00_00_0;
  localparam logic [17:0] V_FETCH1 = 18'b0_1_1_0_0_0_0_01_00_00_00_00_0;
  localparam logic [17:0] V_FETCH0 = 18'b0_0_0_0_0_0_0_01_00_00_00_00_0;
  localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_11_00_00_00_00_0;
  localparam logic [17:0] V_DECILL = 18'b0_0_0_0_0_0_0_11_00_00_00_00_1;
  localparam logic [17:0] V_RTEX   = 18'b0_0_0_0_0_0_1_00_10_00_00_00_0;
  localparam logic [17:0] V_RTWB   = 18'b0_0_0_0_1_1_0_00_00_00_00_00_0;
  localparam logic [17:0] V_IMMEX  = 18'b0_0_0_0_0_0_1_10_00_00_00_00_0;
  localparam logic [17:0] V_ADIWB  = 18'b0_0_0_0_1_1_0_00_00_00_01_00_0;
  localparam logic [17:0] V_MEMRD  = 18'b1_0_0_0_0_0_0_00_00_00_00_00_0;
  localparam logic [17:0] V_MEMWB  = 18'b1_0_0_0_1_0_0_00_00_00_10_01_0;
  localparam logic [17:0] V_MEMWR  = 18'b1_0_0_1_0_0_0_00_00_00_00_00_0;
  localparam logic [17:0] V_BEQ1   = 18'b0_0_1_0_0_0_1_00_01_00_00_00_0;
  localparam logic [17:0] V_BEQ0   = 18'b0_0_0_0_0_0_1_00_01_00_00_00_0;
  localparam logic [17:0] V_JAL    = 18'b0_0_1_0_1_0_0_00_00_01_10_10_0;
  logic clk = 1'b0, reset, carry, zero, alu_zero, mem_ready;
  logic [3:0] op;
  logic [1:0] cz;
  logic iord, irwrite, pcwrite, memwrite, regwrite, flagwrite, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsrc, regdst, memtoreg;
  logic [CNT_W-1:0] retired;
  logic [17:0] obs;
  int checks = 0, errors = 0;
  assign obs = {iord, irwrite, pcwrite, memwrite, regwrite, flagwrite, alusrca,
                alusrcb, aluop, pcsrc, regdst, memtoreg, illegal};
  always #5 clk = ~clk;
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .cz(cz), .carry(carry), .zero(zero),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .memwrite(memwrite), .regwrite(regwrite), .flagwrite(flagwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .regdst(regdst),
    .memtoreg(memtoreg), .illegal(illegal), .retired(retired)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic st(input string tag, input logic [17:0] e);
    #1 chk(tag, 32'(obs), 32'(e));
  endtask
  task automatic ret(input string tag, input int n);
    #1 chk(tag, 32'(retired), 32'(n));
  endtask
  task automatic nxt;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    reset = 1'b0; op = 4'b0000; cz = 2'b10; carry = 1'b1; zero = 1'b0;
    alu_zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    st("reset_outs", V_ZERO);
    ret("reset_ret", 0);
    nxt;
    reset = 1'b1;
    st("adc_fetch", V_FETCH1);
    nxt; st("adc_decode", V_DEC);
    nxt; st("adc_rtexec", V_RTEX);
    nxt; st("adc_rtwb", V_RTWB);
    nxt; st("adc_back_fetch", V_FETCH1); ret("adc_ret", 1);
    carry = 1'b0;
    nxt; st("adc_skip_decode", V_DEC);
    nxt; st("adc_skip_fetch", V_FETCH1); ret("adc_skip_ret", 2);
    cz = 2'b01; zero = 1'b1;
    nxt; st("ndz_decode", V_DEC);
    nxt; st("ndz_rtexec", V_RTEX);
    nxt; st("ndz_rtwb", V_RTWB);
    nxt; ret("ndz_ret", 3);
    op = 4'b0001;
    nxt; st("adi_decode", V_DEC);
    nxt; st("adi_exec", V_IMMEX);
    nxt; st("adi_wb", V_ADIWB);
    nxt; ret("adi_ret", 4);
    op = 4'b0100;
    nxt; st("lw_decode", V_DEC);
    nxt; st("lw_memadr", V_IMMEX);
    nxt; mem_ready = 1'b0; st("lw_memrd_w1", V_MEMRD);
    nxt; st("lw_memrd_w2", V_MEMRD);
    nxt; st("lw_memrd_w3", V_MEMRD);
    nxt; mem_ready = 1'b1; st("lw_memrd_rdy", V_MEMRD);
    nxt; st("lw_memwb", V_MEMWB);
    nxt; st("lw_fetch", V_FETCH1); ret("lw_ret", 5);
    op = 4'b1100;
    nxt; st("beq1_decode", V_DEC);
    nxt; alu_zero = 1'b1; st("beq_taken", V_BEQ1);
    nxt; ret("beq1_ret", 6);
    nxt; st("beq0_decode", V_DEC);
    nxt; alu_zero = 1'b0; st("beq_not_taken", V_BEQ0);
    nxt; st("beq0_fetch", V_FETCH1); ret("beq0_ret", 7);
    op = 4'b1000;
    nxt; st("jal_decode", V_DEC);
    nxt; st("jal", V_JAL);
    nxt; ret("jal_ret", 8);
    op = 4'b1111;
    nxt; st("ill_op_decode", V_DECILL);
    nxt; st("ill_op_fetch", V_FETCH1); ret("ill_op_ret", 8);
    op = 4'b0000; cz = 2'b00;
    nxt; st("ill_cz_decode", V_DECILL);
    nxt; st("ill_cz_fetch", V_FETCH1); ret("ill_cz_ret", 8);
    op = 4'b0101;
    nxt; st("sw_decode", V_DEC);
    nxt; st("sw_memadr", V_IMMEX);
    nxt; mem_ready = 1'b0; st("sw_memwr_w1", V_MEMWR);
    nxt; st("sw_memwr_w2", V_MEMWR);
    reset = 1'b0; st("sw_reset_comb", V_ZERO);
    nxt; st("sw_reset_c1", V_ZERO);
    nxt; st("sw_reset_c2", V_ZERO);
    reset = 1'b1; st("post_reset_fetch_stall", V_FETCH0); ret("post_reset_ret", 0);
    nxt; st("fetch_stall_hold", V_FETCH0);
    mem_ready = 1'b1; st("fetch_ready", V_FETCH1);
    nxt; st("sw2_decode", V_DEC);
    nxt; st("sw2_memadr", V_IMMEX);
    nxt; st("sw2_memwr", V_MEMWR);
    nxt; st("sw2_fetch", V_FETCH1); ret("sw2_ret", 1);
    op = 4'b0000; cz = 2'b10; carry = 1'b0;
    for (int i = 0; i < 14; i++) begin
      nxt;
      nxt;
    end
    ret("pre_wrap_ret", 15);
    nxt;
    nxt; ret("wrap_ret", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
